// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit scheduler: FSM states,
// frame phase flag and header byte construction.
package uart_tx_pkg;

    localparam int IDX_W = 4;
    localparam logic [7:0] HDR_BASE = 8'hA0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_ACK   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        PH_HDR  = 1'b0,
        PH_DATA = 1'b1
    } phase_e;

    function automatic logic [7:0] hdr_byte(input logic [IDX_W-1:0] ch);
        return HDR_BASE | {4'h0, ch};
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting index
// strictly after i_last_grant, wrapping at NUM_REQ.
module rr_arbiter
    import uart_tx_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_any
);

    int w_best_dist;
    int w_dist;

    // Distance 0 is the slot right after the last grant, so the smallest
    // distance among requesters is the round-robin winner.
    always_comb begin
        w_best_dist = NUM_REQ;
        w_dist      = 0;
        o_grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = i - int'(i_last_grant) - 1;
            if (w_dist < 0) begin
                w_dist = w_dist + NUM_REQ;
            end
            if (i_req[i] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                o_grant_idx = IDX_W'(i);
            end
        end
    end

    assign o_any = |i_req;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign o_grant[gi] = o_any && (o_grant_idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one byte-level UART transmitter among up to 16 producers: per-requester
// slots, round-robin grant, and a header+data frame sequenced over start/busy.
module uart_tx_scheduler
    import uart_tx_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter bit HEADER_EN   = 1'b1,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_pulse,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_drop,
    output logic                 tx_start,
    output logic [7:0]           tx_byte,
    input  logic                 tx_busy,
    output logic                 err_timeout,
    output logic                 sched_busy
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    state_e             r_state;
    state_e             w_state_next;
    phase_e             r_phase;
    logic [IDX_W-1:0]   r_last_grant;
    logic [IDX_W-1:0]   r_chan;
    logic [7:0]         r_shadow;
    logic [CNT_W-1:0]   r_tmo_cnt;
    logic               r_tx_start;
    logic [7:0]         r_tx_byte;
    logic               r_err_timeout;
    logic [NUM_REQ-1:0] r_req_drop;

    logic [NUM_REQ-1:0] w_pending;
    logic [NUM_REQ-1:0] w_gnt_oh;
    logic [NUM_REQ-1:0] w_clr;
    logic [NUM_REQ-1:0] w_drop;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic               w_any;
    logic               w_grant_fire;
    logic [7:0]         w_slot [NUM_REQ];
    logic [7:0]         w_sel_data;
    logic               w_tx_start_next;
    logic [7:0]         w_tx_byte_next;
    logic               w_err_next;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .i_req        (w_pending),
        .i_last_grant (r_last_grant),
        .o_grant      (w_gnt_oh),
        .o_grant_idx  (w_gnt_idx),
        .o_any        (w_any)
    );

    assign w_grant_fire = (r_state == ST_IDLE) && w_any;

    // A strobe landing on the slot being granted re-arms it instead of
    // counting as an overwrite; the shadow register still takes the old byte.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
            logic [7:0] r_data;
            logic       r_pend;

            assign w_clr[gi]  = w_grant_fire && w_gnt_oh[gi];
            assign w_drop[gi] = req_pulse[gi] && r_pend && !w_clr[gi];
            assign w_pending[gi] = r_pend;
            assign w_slot[gi]    = r_data;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data <= '0;
                    r_pend <= 1'b0;
                end else if (req_pulse[gi]) begin
                    r_data <= req_data[8*gi +: 8];
                    r_pend <= 1'b1;
                end else if (w_clr[gi]) begin
                    r_pend <= 1'b0;
                end
            end
        end
    endgenerate

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_oh[i]) begin
                w_sel_data = w_sel_data | w_slot[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_phase       <= PH_HDR;
            r_last_grant  <= LAST_RST;
            r_chan        <= '0;
            r_shadow      <= '0;
            r_tmo_cnt     <= '0;
            r_tx_start    <= 1'b0;
            r_tx_byte     <= '0;
            r_err_timeout <= 1'b0;
            r_req_drop    <= '0;
        end else begin
            r_state       <= w_state_next;
            r_tx_start    <= w_tx_start_next;
            r_tx_byte     <= w_tx_byte_next;
            r_err_timeout <= w_err_next;
            r_req_drop    <= w_drop;
            if (w_grant_fire) begin
                r_last_grant <= w_gnt_idx;
                r_chan       <= w_gnt_idx;
                r_shadow     <= w_sel_data;
                r_phase      <= HEADER_EN ? PH_HDR : PH_DATA;
            end else if ((r_state == ST_DONE) && !tx_busy && (r_phase == PH_HDR)) begin
                r_phase <= PH_DATA;
            end
            if (r_state == ST_ACK) begin
                r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
            end else begin
                r_tmo_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_any) w_state_next = ST_START;
            ST_START: if (!tx_busy) w_state_next = ST_ACK;
            ST_ACK: begin
                if (tx_busy) begin
                    w_state_next = ST_DONE;
                end else if (r_tmo_cnt == CNT_LAST) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (!tx_busy) begin
                    w_state_next = (r_phase == PH_HDR) ? ST_START : ST_IDLE;
                end
            end
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // START also holds off while the transmitter is still finishing a byte
    // left over from an aborted frame, so a strobe never overlaps busy.
    always_comb begin
        w_tx_start_next = (r_state == ST_START) && !tx_busy;
        w_tx_byte_next  = r_tx_byte;
        if (w_tx_start_next) begin
            w_tx_byte_next = (r_phase == PH_HDR) ? hdr_byte(r_chan) : r_shadow;
        end
        w_err_next = (r_state == ST_ACK) && !tx_busy && (r_tmo_cnt == CNT_LAST);
    end

    assign tx_start    = r_tx_start;
    assign tx_byte     = r_tx_byte;
    assign err_timeout = r_err_timeout;
    assign req_drop    = r_req_drop;
    assign sched_busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench: expected bytes are queued when requests are strobed and
// popped on every tx_start; directed checks cover timing, drops and timeout.
module tb_uart_tx_scheduler;

    localparam int NREQ = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [NREQ-1:0] req_pulse;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0] req_drop;
    logic            tx_start;
    logic [7:0]      tx_byte;
    logic            tx_busy;
    logic            err_timeout;
    logic            sched_busy;

    logic [NREQ-1:0] req_pulse_nh;
    logic [8*NREQ-1:0] req_data_nh;
    logic [NREQ-1:0] req_drop_nh;
    logic            tx_start_nh;
    logic [7:0]      tx_byte_nh;
    logic            tx_busy_nh;
    logic            err_timeout_nh;
    logic            sched_busy_nh;

    uart_tx_scheduler #(.NUM_REQ(NREQ), .HEADER_EN(1'b1), .ACK_TIMEOUT(16)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_pulse   (req_pulse),
        .req_data    (req_data),
        .req_drop    (req_drop),
        .tx_start    (tx_start),
        .tx_byte     (tx_byte),
        .tx_busy     (tx_busy),
        .err_timeout (err_timeout),
        .sched_busy  (sched_busy)
    );

    uart_tx_scheduler #(.NUM_REQ(NREQ), .HEADER_EN(1'b0), .ACK_TIMEOUT(16)) u_dut_nh (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_pulse   (req_pulse_nh),
        .req_data    (req_data_nh),
        .req_drop    (req_drop_nh),
        .tx_start    (tx_start_nh),
        .tx_byte     (tx_byte_nh),
        .tx_busy     (tx_busy_nh),
        .err_timeout (err_timeout_nh),
        .sched_busy  (sched_busy_nh)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];
    int start_cnt = 0;
    int err_cnt = 0;
    int drop_cnt [NREQ];
    int start_cnt_nh = 0;
    logic [7:0] last_byte_nh = 8'h00;
    logic [7:0] prev_byte = 8'h00;
    logic rst_prev = 1'b0;

    int busy_len = 4;
    bit tx_mute = 1'b0;
    int busy_left = 0;
    int busy_left_nh = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transmitter models: accept a start when idle, stay busy busy_len cycles.
    initial begin
        tx_busy = 1'b0;
        tx_busy_nh = 1'b0;
    end

    always @(posedge clk) begin
        if (tx_busy) begin
            if (busy_left <= 1) tx_busy <= 1'b0;
            else busy_left <= busy_left - 1;
        end else if (tx_start && !tx_mute) begin
            tx_busy <= 1'b1;
            busy_left <= busy_len;
        end
    end

    always @(posedge clk) begin
        if (tx_busy_nh) begin
            if (busy_left_nh <= 1) tx_busy_nh <= 1'b0;
            else busy_left_nh <= busy_left_nh - 1;
        end else if (tx_start_nh) begin
            tx_busy_nh <= 1'b1;
            busy_left_nh <= 3;
        end
    end

    initial begin
        for (int i = 0; i < NREQ; i++) drop_cnt[i] = 0;
    end

    always @(negedge clk) begin
        if (rst_n && rst_prev) begin
            if (tx_start) begin
                start_cnt++;
                $display("[%0t] tx_start byte=%02h", $time, tx_byte);
                chk("start_while_busy", 32'(tx_busy), 32'd0);
                chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("tx_byte", 32'(tx_byte), 32'(exp_q.pop_front()));
            end else begin
                chk("byte_stable", 32'(tx_byte), 32'(prev_byte));
            end
            if (err_timeout) begin
                err_cnt++;
                $display("[%0t] err_timeout", $time);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_drop[i]) begin
                    drop_cnt[i]++;
                    $display("[%0t] req_drop[%0d]", $time, i);
                end
            end
            if (tx_start_nh) begin
                start_cnt_nh++;
                last_byte_nh = tx_byte_nh;
                $display("[%0t] nh tx_start byte=%02h", $time, tx_byte_nh);
            end
        end
        prev_byte = tx_byte;
        rst_prev = rst_n;
    end

    task automatic pulse(input logic [NREQ-1:0] mask, input logic [8*NREQ-1:0] data);
        @(negedge clk);
        req_pulse = mask;
        req_data  = data;
        @(negedge clk);
        req_pulse = '0;
    endtask

    task automatic push_frame(input logic [7:0] hdr, input logic [7:0] data);
        exp_q.push_back(hdr);
        exp_q.push_back(data);
    endtask

    task automatic wait_start(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (tx_start) break;
        end
        if (!tx_start) chk("wait_start_tmo", 32'(tx_start), 32'd1);
    endtask

    task automatic wait_busy(input logic level, input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (tx_busy == level) break;
        end
        if (tx_busy != level) chk("wait_busy_tmo", 32'(tx_busy), 32'(level));
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || sched_busy || tx_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        chk("drain_idle", 32'(sched_busy), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int snap;
        rst_n = 1'b1;
        req_pulse = '0;
        req_data = '0;
        req_pulse_nh = '0;
        req_data_nh = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_byte", 32'(tx_byte), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_sched_busy", 32'(sched_busy), 32'd0);
        chk("rst_req_drop", 32'(req_drop), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request: header A2 then 5C, with latency and inter-byte gap.
        busy_len = 20;
        snap = start_cnt;
        push_frame(8'hA2, 8'h5C);
        pulse(4'b0100, {8'h00, 8'h5C, 8'h00, 8'h00});
        wait_start(10, n);
        chk("strobe_to_start", 32'(n + 1), 32'd3);
        wait_busy(1'b1, 10, n);
        wait_busy(1'b0, 40, n);
        wait_start(10, n);
        chk("hdr_data_gap", 32'(n), 32'd2);
        wait_drain(100);
        chk("single_starts", 32'(start_cnt - snap), 32'd2);

        // Round-robin from reset, then a wrap from last grant 3 to 0.
        busy_len = 4;
        do_reset();
        push_frame(8'hA0, 8'h10);
        push_frame(8'hA1, 8'h11);
        push_frame(8'hA2, 8'h12);
        push_frame(8'hA3, 8'h13);
        pulse(4'b1111, {8'h13, 8'h12, 8'h11, 8'h10});
        wait_drain(400);
        push_frame(8'hA0, 8'h20);
        push_frame(8'hA3, 8'h23);
        pulse(4'b1001, {8'h23, 8'h00, 8'h00, 8'h20});
        wait_drain(200);

        // Overwrite of req 1 while req 0's frame is in flight.
        snap = drop_cnt[1];
        push_frame(8'hA0, 8'h40);
        push_frame(8'hA1, 8'hBB);
        pulse(4'b0001, {24'h0, 8'h40});
        repeat (3) @(negedge clk);
        pulse(4'b0010, {16'h0, 8'hAA, 8'h00});
        pulse(4'b0010, {16'h0, 8'hBB, 8'h00});
        wait_drain(200);
        chk("drop_req1", 32'(drop_cnt[1] - snap), 32'd1);

        // Strobe req 1 again exactly in its grant cycle: no drop, two frames.
        snap = drop_cnt[1];
        push_frame(8'hA1, 8'h55);
        push_frame(8'hA1, 8'h66);
        @(negedge clk);
        req_pulse = 4'b0010;
        req_data  = {16'h0, 8'h55, 8'h00};
        @(negedge clk);
        req_data  = {16'h0, 8'h66, 8'h00};
        @(negedge clk);
        req_pulse = '0;
        wait_drain(200);
        chk("grant_strobe_nodrop", 32'(drop_cnt[1] - snap), 32'd0);

        // Timeout on req 2's header, then req 3 is served normally.
        snap = err_cnt;
        tx_mute = 1'b1;
        exp_q.push_back(8'hA2);
        push_frame(8'hA3, 8'h78);
        pulse(4'b1100, {8'h78, 8'h77, 16'h0});
        wait_start(10, n);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (err_timeout) break;
        end
        chk("timeout_delay", 32'(n), 32'd16);
        chk("timeout_idle", 32'(sched_busy), 32'd0);
        tx_mute = 1'b0;
        wait_drain(200);
        chk("timeout_count", 32'(err_cnt - snap), 32'd1);

        // Reset while waiting for the header byte to finish.
        busy_len = 10;
        exp_q.push_back(8'hA0);
        pulse(4'b0001, {24'h0, 8'h90});
        wait_start(10, n);
        wait_busy(1'b1, 10, n);
        pulse(4'b0100, {8'h00, 8'h91, 16'h0});
        rst_n = 1'b0;
        #1;
        chk("midrst_tx_start", 32'(tx_start), 32'd0);
        chk("midrst_tx_byte", 32'(tx_byte), 32'd0);
        chk("midrst_err", 32'(err_timeout), 32'd0);
        chk("midrst_sched_busy", 32'(sched_busy), 32'd0);
        chk("midrst_req_drop", 32'(req_drop), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        snap = start_cnt;
        repeat (40) @(negedge clk);
        chk("midrst_no_pending", 32'(start_cnt - snap), 32'd0);
        chk("midrst_still_idle", 32'(sched_busy), 32'd0);

        // Data-only variant.
        snap = start_cnt_nh;
        @(negedge clk);
        req_pulse_nh = 4'b0001;
        req_data_nh  = {24'h0, 8'h7F};
        @(negedge clk);
        req_pulse_nh = '0;
        repeat (30) @(negedge clk);
        chk("nh_starts", 32'(start_cnt_nh - snap), 32'd1);
        chk("nh_byte", 32'(last_byte_nh), 32'h7F);
        chk("nh_idle", 32'(sched_busy_nh), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
